// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the debug-module hart front end: DM register
// addresses, dmcontrol/dmstatus/abstractcs bit positions, and the state and
// error encodings used by dm_hart_ctrl and dm_abstract_cmd.
// -----------------------------------------------------------------------------
package dm_pkg;

  // DM register addresses (DMI address space)
  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;

  // DMI operations
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  // dmcontrol fields
  localparam int DMC_HALTREQ   = 31;
  localparam int DMC_RESUMEREQ = 30;
  localparam int DMC_DMACTIVE  = 0;

  // dmstatus fields
  localparam int DMS_ALLRESUMEACK = 17;
  localparam int DMS_ANYRESUMEACK = 16;
  localparam int DMS_ALLUNAVAIL   = 13;
  localparam int DMS_ANYUNAVAIL   = 12;
  localparam int DMS_ALLRUNNING   = 11;
  localparam int DMS_ANYRUNNING   = 10;
  localparam int DMS_ALLHALTED    = 9;
  localparam int DMS_ANYHALTED    = 8;
  localparam logic [3:0] DMS_VERSION = 4'd2;

  // abstractcs fields
  localparam int ACS_BUSY       = 12;
  localparam int ACS_CMDERR_LSB = 8;
  localparam logic [3:0] ACS_DATACOUNT = 4'd1;

  typedef enum logic [1:0] {
    RUN_RUNNING        = 2'd0,
    RUN_HALT_PENDING   = 2'd1,
    RUN_HALTED         = 2'd2,
    RUN_RESUME_PENDING = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_EXEC = 2'd1,
    CMD_DONE = 2'd2
  } cmd_state_e;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

endpackage

// File: rtl/dm_abstract_cmd.sv
// -----------------------------------------------------------------------------
// dm_abstract_cmd
// Abstract-command engine: validates command writes, owns data0 and the
// sticky cmderr field, and performs the single register-bus access to the
// hart (dcsr only).
//
// Ports:
//   clk_i, reset_i      clock, asynchronous active-low reset
//   clear               synchronous clear to reset state (dmactive low)
//   cmd_wr/cmd_wdata    command register write
//   data0_wr/_wdata     data0 register write
//   cmderr_clr_wr/_clr  abstractcs write, W1C mask for cmderr
//   halted              hart is in the HALTED run state
//   busy, cmderr, data0 register view for the debugger
//   bus_en/_wr/_addr    register-bus strobe, direction, regno
//   bus_oe/_wdata       write data and its output enable
//   bus_rdata           value currently on the shared data bus
// -----------------------------------------------------------------------------
module dm_abstract_cmd
  import dm_pkg::*;
#(
  parameter logic [15:0] DCSR_ADDR = 16'h07B0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_wdata,
  input  logic        data0_wr,
  input  logic [31:0] data0_wdata,
  input  logic        cmderr_clr_wr,
  input  logic [2:0]  cmderr_clr,
  input  logic        halted,
  output logic        busy,
  output logic [2:0]  cmderr,
  output logic [31:0] data0,
  output logic        bus_en,
  output logic        bus_wr,
  output logic [15:0] bus_addr,
  output logic        bus_oe,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  cmd_state_e  state_q, state_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic [31:0] data0_q, data0_d;
  logic        wr_q, wr_d;
  logic [15:0] regno_q, regno_d;

  logic [7:0]  cmd_type;
  logic [2:0]  cmd_aarsize;
  logic        cmd_transfer;
  logic        cmd_write;
  logic [15:0] cmd_regno;
  logic        cmd_notsup;

  assign cmd_type     = cmd_wdata[31:24];
  assign cmd_aarsize  = cmd_wdata[22:20];
  assign cmd_transfer = cmd_wdata[17];
  assign cmd_write    = cmd_wdata[16];
  assign cmd_regno    = cmd_wdata[15:0];

  // Only access-register commands of 32-bit size to dcsr are supported; the
  // regno is irrelevant when nothing is transferred.
  assign cmd_notsup = (cmd_type != 8'd0) || (cmd_aarsize != 3'd2) ||
                      (cmd_transfer && (cmd_regno != DCSR_ADDR));

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{cmd_wdata[23], cmd_wdata[19:18]};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= CMD_IDLE;
      cmderr_q <= CMDERR_NONE;
      data0_q  <= '0;
      wr_q     <= 1'b0;
      regno_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmderr_q <= cmderr_d;
      data0_q  <= data0_d;
      wr_q     <= wr_d;
      regno_q  <= regno_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cmderr_d = cmderr_q;
    data0_d  = data0_q;
    wr_d     = wr_q;
    regno_d  = regno_q;

    unique case (state_q)
      CMD_EXEC: begin
        state_d = CMD_DONE;
        // Read result is taken from the bus on the edge that ends EXEC.
        if (!wr_q) data0_d = bus_rdata;
      end
      CMD_DONE: state_d = CMD_IDLE;
      default:  state_d = state_q;
    endcase

    if (data0_wr) data0_d = data0_wdata;

    if (cmderr_clr_wr) cmderr_d = cmderr_q & ~cmderr_clr;

    // A pending error blocks new commands until the debugger clears it.
    if (cmd_wr && (cmderr_q == CMDERR_NONE)) begin
      if (state_q != CMD_IDLE) begin
        cmderr_d = CMDERR_BUSY;
      end else if (cmd_notsup) begin
        cmderr_d = CMDERR_NOTSUP;
      end else if (!halted) begin
        cmderr_d = CMDERR_HALTRESUME;
      end else if (cmd_transfer) begin
        state_d = CMD_EXEC;
        wr_d    = cmd_write;
        regno_d = cmd_regno;
      end
    end

    if (clear) begin
      state_d  = CMD_IDLE;
      cmderr_d = CMDERR_NONE;
      data0_d  = '0;
      wr_d     = 1'b0;
      regno_d  = '0;
    end
  end

  assign busy      = (state_q != CMD_IDLE);
  assign cmderr    = cmderr_q;
  assign data0     = data0_q;
  assign bus_en    = (state_q == CMD_EXEC);
  assign bus_wr    = bus_en & wr_q;
  assign bus_addr  = bus_en ? regno_q : 16'd0;
  assign bus_oe    = bus_en & wr_q;
  assign bus_wdata = data0_q;

endmodule

// File: rtl/dm_hart_ctrl.sv
// -----------------------------------------------------------------------------
// dm_hart_ctrl
// Debug-module front end for one hart. Decodes DMI register accesses,
// runs the halt/resume handshake with the hart and forwards abstract
// commands to the hart register bus through dm_abstract_cmd.
//
// Build option: define DM_HALT_TIMEOUT_EN to flag the hart unavailable when
// a halt request is not acknowledged within HALT_TIMEOUT cycles.
//
// Ports:
//   clk_i, reset_i              clock, asynchronous active-low reset
//   dmi_req_*                   request: valid/ready, addr, op, wdata
//   dmi_resp_valid_o/_data_o    one-cycle response strobe and read data
//   hart_halt_req_o             level halt request (falling edge = resume)
//   hart_rd_wr_*                register bus; data driven only on writes
//   hart_halt_ack_i             single-cycle halt acknowledge
//   hart_resume_ack_i           single-cycle resume acknowledge
//   hart_stepping_i             step status (not used by the register view)
//   hart_first_step_exec_i      hart is executing its single step
// -----------------------------------------------------------------------------
module dm_hart_ctrl
  import dm_pkg::*;
#(
  parameter int          HALT_TIMEOUT = 1024,
  parameter logic [15:0] DCSR_ADDR    = 16'h07B0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  input  logic [6:0]  dmi_addr_i,
  input  logic [1:0]  dmi_op_i,
  input  logic [31:0] dmi_wdata_i,
  output logic        dmi_resp_valid_o,
  output logic [31:0] dmi_resp_data_o,
  output logic        hart_halt_req_o,
  output logic        hart_rd_wr_en_o,
  output logic        hart_rd_wr_o,
  output logic [15:0] hart_rd_wr_address_o,
  inout  wire  [31:0] hart_rd_wr_data_io,
  input  logic        hart_halt_ack_i,
  input  logic        hart_resume_ack_i,
  input  logic        hart_stepping_i,
  input  logic        hart_first_step_exec_i
);

  logic        resp_valid_q;
  logic [31:0] resp_data_q;
  logic        haltreq_q, dmactive_q;
  run_state_e  run_state_q, run_state_d;
  logic        resumeack_q, resumeack_d;
  logic        unavail;

  logic        req_fire, rd_fire, wr_fire;
  logic        dmc_wr, haltreq_eff, resumereq_eff, dmactive_eff;
  logic [31:0] rdata, dmstatus, abstractcs;

  logic        cmd_busy;
  logic [2:0]  cmd_err;
  logic [31:0] data0;
  logic        bus_oe;
  logic [31:0] bus_wdata;

  logic unused_step;
  assign unused_step = hart_stepping_i;

  // The response cycle doubles as the busy cycle, giving 1 request / 2 cycles.
  assign dmi_req_ready_o = ~resp_valid_q;
  assign req_fire = dmi_req_valid_i & dmi_req_ready_o;
  assign rd_fire  = req_fire & (dmi_op_i == DMI_OP_READ);
  assign wr_fire  = req_fire & (dmi_op_i == DMI_OP_WRITE);

  // A dmcontrol write takes effect on the same edge that accepts it, so the
  // run FSM and the dmactive clear look at the incoming value directly.
  assign dmc_wr        = wr_fire & (dmi_addr_i == ADDR_DMCONTROL);
  assign haltreq_eff   = dmc_wr ? dmi_wdata_i[DMC_HALTREQ]  : haltreq_q;
  assign dmactive_eff  = dmc_wr ? dmi_wdata_i[DMC_DMACTIVE] : dmactive_q;
  assign resumereq_eff = dmc_wr & dmi_wdata_i[DMC_RESUMEREQ] & ~dmi_wdata_i[DMC_HALTREQ];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      haltreq_q    <= 1'b0;
      dmactive_q   <= 1'b0;
      run_state_q  <= RUN_RUNNING;
      resumeack_q  <= 1'b0;
    end else begin
      resp_valid_q <= req_fire;
      resp_data_q  <= rd_fire ? rdata : 32'd0;
      if (dmc_wr) begin
        haltreq_q  <= dmi_wdata_i[DMC_HALTREQ];
        dmactive_q <= dmi_wdata_i[DMC_DMACTIVE];
      end
      run_state_q  <= run_state_d;
      resumeack_q  <= resumeack_d;
    end
  end

  always_comb begin
    run_state_d = run_state_q;
    resumeack_d = resumeack_q;
    unique case (run_state_q)
      RUN_RUNNING:
        if (haltreq_eff) run_state_d = RUN_HALT_PENDING;
      RUN_HALT_PENDING:
        if (hart_halt_ack_i)   run_state_d = RUN_HALTED;
        else if (!haltreq_eff) run_state_d = RUN_RUNNING;
      RUN_HALTED:
        // Clearing haltreq alone keeps the hart halted; only resumereq leaves.
        if (resumereq_eff) run_state_d = RUN_RESUME_PENDING;
      RUN_RESUME_PENDING:
        if (hart_resume_ack_i) begin
          run_state_d = RUN_RUNNING;
          resumeack_d = 1'b1;
        end
      default: run_state_d = RUN_RUNNING;
    endcase
    if (resumereq_eff) resumeack_d = 1'b0;
    if (!dmactive_eff) begin
      run_state_d = RUN_RUNNING;
      resumeack_d = 1'b0;
    end
  end

  assign hart_halt_req_o = (run_state_q == RUN_HALT_PENDING) || (run_state_q == RUN_HALTED);

`ifdef DM_HALT_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        unavail_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      to_cnt_q  <= '0;
      unavail_q <= 1'b0;
    end else if (!dmactive_eff) begin
      to_cnt_q  <= '0;
      unavail_q <= 1'b0;
    end else begin
      if (run_state_q == RUN_HALT_PENDING) begin
        // Counter stops once the flag is set, so it never wraps.
        if (!unavail_q) to_cnt_q <= to_cnt_q + 16'd1;
        if (to_cnt_q == 16'(HALT_TIMEOUT - 1)) unavail_q <= 1'b1;
      end else begin
        to_cnt_q <= '0;
      end
      if (hart_halt_ack_i) unavail_q <= 1'b0;
    end
  end

  assign unavail = unavail_q;
`else
  assign unavail = 1'b0;
`endif

  always_comb begin
    dmstatus = '0;
    dmstatus[3:0]            = DMS_VERSION;
    dmstatus[DMS_ALLHALTED]  = (run_state_q == RUN_HALTED) & ~hart_first_step_exec_i;
    dmstatus[DMS_ANYHALTED]  = (run_state_q == RUN_HALTED) & ~hart_first_step_exec_i;
    dmstatus[DMS_ALLRUNNING] = (run_state_q == RUN_RUNNING) | (run_state_q == RUN_HALT_PENDING) |
                               hart_first_step_exec_i;
    dmstatus[DMS_ANYRUNNING] = dmstatus[DMS_ALLRUNNING];
    dmstatus[DMS_ALLUNAVAIL] = unavail;
    dmstatus[DMS_ANYUNAVAIL] = unavail;
    dmstatus[DMS_ALLRESUMEACK] = resumeack_q;
    dmstatus[DMS_ANYRESUMEACK] = resumeack_q;
  end

  always_comb begin
    abstractcs = '0;
    abstractcs[3:0]                         = ACS_DATACOUNT;
    abstractcs[ACS_CMDERR_LSB+2:ACS_CMDERR_LSB] = cmd_err;
    abstractcs[ACS_BUSY]                    = cmd_busy;
  end

  always_comb begin
    rdata = '0;
    unique case (dmi_addr_i)
      ADDR_DATA0:      rdata = data0;
      ADDR_DMCONTROL:  rdata = {haltreq_q, 30'd0, dmactive_q};
      ADDR_DMSTATUS:   rdata = dmstatus;
      ADDR_ABSTRACTCS: rdata = abstractcs;
      default:         rdata = '0;
    endcase
  end

  assign dmi_resp_valid_o = resp_valid_q;
  assign dmi_resp_data_o  = resp_data_q;

  dm_abstract_cmd #(
    .DCSR_ADDR (DCSR_ADDR)
  ) u_abstract_cmd (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .clear         (~dmactive_eff),
    .cmd_wr        (wr_fire & (dmi_addr_i == ADDR_COMMAND)),
    .cmd_wdata     (dmi_wdata_i),
    .data0_wr      (wr_fire & (dmi_addr_i == ADDR_DATA0)),
    .data0_wdata   (dmi_wdata_i),
    .cmderr_clr_wr (wr_fire & (dmi_addr_i == ADDR_ABSTRACTCS)),
    .cmderr_clr    (dmi_wdata_i[ACS_CMDERR_LSB+2:ACS_CMDERR_LSB]),
    .halted        (run_state_q == RUN_HALTED),
    .busy          (cmd_busy),
    .cmderr        (cmd_err),
    .data0         (data0),
    .bus_en        (hart_rd_wr_en_o),
    .bus_wr        (hart_rd_wr_o),
    .bus_addr      (hart_rd_wr_address_o),
    .bus_oe        (bus_oe),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (hart_rd_wr_data_io)
  );

  assign hart_rd_wr_data_io = bus_oe ? bus_wdata : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_dm_hart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_hart_ctrl
// Directed bench for dm_hart_ctrl. Each DMI request pushes its expected
// response; a monitor pops and compares on every response strobe. Expected
// hart register-bus strobes are queued and checked the same way.
// -----------------------------------------------------------------------------
module tb_dm_hart_ctrl;

  localparam logic [6:0] A_DATA0  = 7'h04;
  localparam logic [6:0] A_DMCTRL = 7'h10;
  localparam logic [6:0] A_DMSTAT = 7'h11;
  localparam logic [6:0] A_ACS    = 7'h16;
  localparam logic [6:0] A_CMD    = 7'h17;
`ifdef DM_HALT_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        clk_i, reset_i;
  logic        dmi_req_valid_i, dmi_req_ready_o;
  logic [6:0]  dmi_addr_i;
  logic [1:0]  dmi_op_i;
  logic [31:0] dmi_wdata_i;
  logic        dmi_resp_valid_o;
  logic [31:0] dmi_resp_data_o;
  logic        hart_halt_req_o, hart_rd_wr_en_o, hart_rd_wr_o;
  logic [15:0] hart_rd_wr_address_o;
  wire  [31:0] hart_bus;
  logic        hart_halt_ack_i, hart_resume_ack_i, hart_stepping_i, hart_first_step_exec_i;
  logic [31:0] hart_rdata;

  // Hart model: answers register reads on the shared bus.
  assign hart_bus = (hart_rd_wr_en_o && !hart_rd_wr_o) ? hart_rdata : 32'hzzzz_zzzz;

  dm_hart_ctrl #(.HALT_TIMEOUT(TO), .DCSR_ADDR(16'h07B0)) dut (
    .clk_i                  (clk_i),
    .reset_i                (reset_i),
    .dmi_req_valid_i        (dmi_req_valid_i),
    .dmi_req_ready_o        (dmi_req_ready_o),
    .dmi_addr_i             (dmi_addr_i),
    .dmi_op_i               (dmi_op_i),
    .dmi_wdata_i            (dmi_wdata_i),
    .dmi_resp_valid_o       (dmi_resp_valid_o),
    .dmi_resp_data_o        (dmi_resp_data_o),
    .hart_halt_req_o        (hart_halt_req_o),
    .hart_rd_wr_en_o        (hart_rd_wr_en_o),
    .hart_rd_wr_o           (hart_rd_wr_o),
    .hart_rd_wr_address_o   (hart_rd_wr_address_o),
    .hart_rd_wr_data_io     (hart_bus),
    .hart_halt_ack_i        (hart_halt_ack_i),
    .hart_resume_ack_i      (hart_resume_ack_i),
    .hart_stepping_i        (hart_stepping_i),
    .hart_first_step_exec_i (hart_first_step_exec_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [31:0] data;
  } bus_exp_t;

  logic [31:0] exp_q[$];
  string       name_q[$];
  bus_exp_t    bus_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          strobe_cnt = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  // Scoreboard monitor: responses and bus strobes, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (dmi_resp_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_resp: got %h, expected no response", dmi_resp_data_o);
      end else begin
        check(name_q.pop_front(), dmi_resp_data_o, exp_q.pop_front());
      end
    end
    if (hart_rd_wr_en_o) begin
      strobe_cnt++;
      if (bus_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_strobe: got addr %h, expected no strobe", hart_rd_wr_address_o);
      end else begin
        bus_exp_t e;
        e = bus_q.pop_front();
        check("bus_addr", {16'd0, hart_rd_wr_address_o}, {16'd0, e.addr});
        check("bus_rd_wr", {31'd0, hart_rd_wr_o}, {31'd0, e.wr});
        if (e.wr) check("bus_wdata", hart_bus, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Issues one request; returns #1 after the accepting edge (response cycle).
  task automatic dmi(input logic [6:0] a, input logic [1:0] op, input logic [31:0] wd,
                     input logic [31:0] exp, input string nm);
    int t = 0;
    while (!dmi_req_ready_o && t < 10) begin tick(1); t++; end
    if (!dmi_req_ready_o) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout %s: got ready 0, expected 1", nm);
    end else begin
      dmi_req_valid_i = 1'b1; dmi_addr_i = a; dmi_op_i = op; dmi_wdata_i = wd;
      exp_q.push_back(exp); name_q.push_back(nm);
      tick(1);
      dmi_req_valid_i = 1'b0; dmi_op_i = 2'd0;
    end
  endtask

  task automatic rd(input logic [6:0] a, input logic [31:0] exp, input string nm);
    dmi(a, 2'd1, 32'd0, exp, nm);
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d, input string nm);
    dmi(a, 2'd2, d, 32'd0, nm);
  endtask

  task automatic halt_ack_pulse();
    hart_halt_ack_i = 1'b1; tick(1); hart_halt_ack_i = 1'b0;
  endtask

  initial begin
    int saved;
    reset_i = 1'b0; dmi_req_valid_i = 1'b0; dmi_addr_i = '0; dmi_op_i = '0; dmi_wdata_i = '0;
    hart_halt_ack_i = 1'b0; hart_resume_ack_i = 1'b0; hart_stepping_i = 1'b0;
    hart_first_step_exec_i = 1'b0; hart_rdata = '0;
    tick(3);
    check("rst_ready", {31'd0, dmi_req_ready_o}, 32'd1);
    check("rst_resp_valid", {31'd0, dmi_resp_valid_o}, 32'd0);
    check("rst_resp_data", dmi_resp_data_o, 32'd0);
    check("rst_halt_req", {31'd0, hart_halt_req_o}, 32'd0);
    check("rst_bus_en", {31'd0, hart_rd_wr_en_o}, 32'd0);
    check("rst_bus_addr", {16'd0, hart_rd_wr_address_o}, 32'd0);
    reset_i = 1'b1;
    tick(1);

    rd(A_DMSTAT, 32'h0000_0C02, "dmstatus_after_reset");
    check("ready_low_in_resp", {31'd0, dmi_req_ready_o}, 32'd0);
    rd(A_ACS, 32'h0000_0001, "abstractcs_after_reset");
    rd(7'h3F, 32'd0, "unmapped_read");

    // Halt
    wr(A_DMCTRL, 32'h8000_0001, "wr_haltreq");
    check("halt_req_after_write", {31'd0, hart_halt_req_o}, 32'd1);
    tick(2);
    halt_ack_pulse();
    rd(A_DMSTAT, 32'h0000_0302, "dmstatus_halted");
    rd(A_DMCTRL, 32'h8000_0001, "dmcontrol_readback");

    // Abstract write of dcsr, busy visible two edges after the command
    wr(A_DATA0, 32'h4000_0003, "wr_data0");
    bus_q.push_back({16'h07B0, 1'b1, 32'h4000_0003});
    wr(A_CMD, 32'h0023_07B0, "wr_cmd_write");
    rd(A_ACS, 32'h0000_1001, "abstractcs_busy");
    rd(A_ACS, 32'h0000_0001, "abstractcs_write_ok");

    // Abstract read of dcsr
    hart_rdata = 32'h4000_00C3;
    bus_q.push_back({16'h07B0, 1'b0, 32'd0});
    wr(A_CMD, 32'h0022_07B0, "wr_cmd_read");
    rd(A_DATA0, 32'h4000_00C3, "data0_after_read");

    // Command while busy
    bus_q.push_back({16'h07B0, 1'b0, 32'd0});
    wr(A_CMD, 32'h0022_07B0, "wr_cmd_first");
    wr(A_CMD, 32'h0022_07B0, "wr_cmd_collide");
    rd(A_ACS, 32'h0000_0101, "cmderr_busy");
    wr(A_ACS, 32'h0000_0700, "clr_cmderr_busy");

    // Resume
    wr(A_DMCTRL, 32'h4000_0001, "wr_resumereq");
    check("halt_req_after_resume", {31'd0, hart_halt_req_o}, 32'd0);
    rd(A_DMSTAT, 32'h0000_0002, "dmstatus_resume_pending");
    hart_resume_ack_i = 1'b1; tick(1); hart_resume_ack_i = 1'b0;
    rd(A_DMSTAT, 32'h0003_0C02, "dmstatus_resumed");

    // Command errors while running
    saved = strobe_cnt;
    wr(A_CMD, 32'h0022_07B0, "wr_cmd_running");
    rd(A_ACS, 32'h0000_0401, "cmderr_haltresume");
    check("no_strobe_running", strobe_cnt, saved);
    wr(A_ACS, 32'h0000_0700, "clr_cmderr");
    rd(A_ACS, 32'h0000_0001, "cmderr_cleared");
    wr(A_CMD, 32'h0022_07B1, "wr_cmd_bad_regno");
    rd(A_ACS, 32'h0000_0201, "cmderr_notsup");
    wr(A_ACS, 32'h0000_0700, "clr_cmderr_notsup");

    // haltreq beats resumereq; clearing haltreq while halted keeps the request
    wr(A_DMCTRL, 32'h8000_0001, "wr_haltreq2");
    halt_ack_pulse();
    wr(A_DMCTRL, 32'hC000_0001, "wr_halt_and_resume");
    rd(A_DMSTAT, 32'h0003_0302, "dmstatus_halt_wins");
    wr(A_DMCTRL, 32'h0000_0001, "wr_clear_haltreq");
    check("halt_req_held_halted", {31'd0, hart_halt_req_o}, 32'd1);

    // dmactive = 0 clears run state, resumeack and data0
    wr(A_DMCTRL, 32'h0000_0000, "wr_dmactive0");
    check("halt_req_dmactive0", {31'd0, hart_halt_req_o}, 32'd0);
    wr(A_DATA0, 32'h0000_1234, "wr_data0_inactive");
    rd(A_DATA0, 32'h0000_0000, "data0_inactive");
    rd(A_DMSTAT, 32'h0000_0C02, "dmstatus_inactive");

    // Halt request withdrawn before ack
    wr(A_DMCTRL, 32'h8000_0001, "wr_haltreq3");
    wr(A_DMCTRL, 32'h0000_0001, "wr_withdraw");
    check("halt_req_withdrawn", {31'd0, hart_halt_req_o}, 32'd0);
    rd(A_DMSTAT, 32'h0000_0C02, "dmstatus_withdrawn");

`ifdef DM_HALT_TIMEOUT_EN
    wr(A_DMCTRL, 32'h8000_0001, "wr_haltreq_timeout");
    tick(10);
    rd(A_DMSTAT, 32'h0000_3C02, "dmstatus_unavail");
    check("halt_req_during_timeout", {31'd0, hart_halt_req_o}, 32'd1);
    halt_ack_pulse();
    rd(A_DMSTAT, 32'h0000_0302, "dmstatus_unavail_cleared");
`endif

    // Async reset in the middle of a command
    wr(A_DMCTRL, 32'h8000_0001, "wr_haltreq4");
    halt_ack_pulse();
    wr(A_CMD, 32'h0023_07B0, "wr_cmd_reset");
    check("mid_cmd_strobe", {31'd0, hart_rd_wr_en_o}, 32'd1);
    #1 reset_i = 1'b0;
    #1;
    check("reset_strobe_drop", {31'd0, hart_rd_wr_en_o}, 32'd0);
    check("reset_halt_req", {31'd0, hart_halt_req_o}, 32'd0);
    check("reset_ready", {31'd0, dmi_req_ready_o}, 32'd1);
    // The response to the command write is cut off by the reset.
    void'(exp_q.pop_back());
    void'(name_q.pop_back());
    tick(2);
    reset_i = 1'b1;
    tick(1);
    rd(A_DMSTAT, 32'h0000_0C02, "dmstatus_post_reset");
    rd(A_DATA0, 32'h0000_0000, "data0_post_reset");

    tick(3);
    check("resp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
